// File: rtl/encoder_m.sv
// Generic valid/ready FIFO: DEPTH entries, head word presented combinationally.
// Latency: a word pushed at edge N is at the head after edge N when the FIFO was empty.
// Backpressure: push_rdy deasserts when full, regardless of pop_rdy; held low during reset.
module fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign push_rdy = rst_n && (count < CW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;
    assign push     = push_vld && push_rdy;
    assign pop      = pop_vld && pop_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Storage carries no reset: pop_dat is masked to zero whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end
endmodule

// LEGv8 instruction encoder: field set in, 32-bit encoded word out via a 2-entry FIFO.
// Latency: word visible at the output the cycle after acceptance; err pulses the cycle after a reject.
// Backpressure: in_ready = FIFO not full (independent of out_ready); rejects still handshake.
module encoder_m (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [31:0] imm,
    input  logic [1:0]  hw,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instruction,
    output logic        err
);
    typedef enum logic [3:0] {
        OP_B, OP_BL, OP_CBZ, OP_CBNZ, OP_LDUR, OP_STUR, OP_ADD, OP_SUB,
        OP_AND, OP_ORR, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_MOVK, OP_ILL
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [31:0] imm;
        logic [1:0]  hw;
    } req_t;

    req_t        req_dat;
    logic [31:0] enc_dat;
    logic        bad, accept, enc_vld;

    // True when v, read as two's complement, fits in a signed field of the given width.
    function automatic logic fits_s(input logic [31:0] v, input int bits);
        logic signed [31:0] hi;
        hi = $signed(v) >>> (bits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

    assign req_dat = '{op: op_e'(op), rd: rd, rn: rn, rm: rm, imm: imm, hw: hw};

    always_comb begin
        enc_dat = '0;
        bad     = 1'b0;
        case (req_dat.op)
            OP_B, OP_BL: begin
                enc_dat = {(req_dat.op == OP_BL) ? 6'b100101 : 6'b000101, req_dat.imm[25:0]};
                bad     = !fits_s(req_dat.imm, 26);
            end
            OP_CBZ, OP_CBNZ: begin
                enc_dat = {7'b1011010, req_dat.op == OP_CBNZ, req_dat.imm[18:0], req_dat.rd};
                bad     = !fits_s(req_dat.imm, 19);
            end
            OP_LDUR, OP_STUR: begin
                enc_dat = {9'b111110000, req_dat.op == OP_LDUR, 1'b0, req_dat.imm[8:0],
                           2'b00, req_dat.rn, req_dat.rd};
                bad     = !fits_s(req_dat.imm, 9);
            end
            OP_ADD: enc_dat = {11'b10001011000, req_dat.rm, 6'd0, req_dat.rn, req_dat.rd};
            OP_SUB: enc_dat = {11'b11001011000, req_dat.rm, 6'd0, req_dat.rn, req_dat.rd};
            OP_AND: enc_dat = {11'b10001010000, req_dat.rm, 6'd0, req_dat.rn, req_dat.rd};
            OP_ORR: enc_dat = {11'b10101010000, req_dat.rm, 6'd0, req_dat.rn, req_dat.rd};
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI: begin
                case (req_dat.op)
                    OP_ADDI: enc_dat[31:22] = 10'b1001000100;
                    OP_SUBI: enc_dat[31:22] = 10'b1101000100;
                    OP_ANDI: enc_dat[31:22] = 10'b1001001000;
                    default: enc_dat[31:22] = 10'b1011001000;
                endcase
                enc_dat[21:0] = {req_dat.imm[11:0], req_dat.rn, req_dat.rd};
                bad           = !fits_s(req_dat.imm, 12);
            end
            OP_MOVK: begin
                enc_dat = {9'b111100101, req_dat.hw, req_dat.imm[15:0], req_dat.rd};
                bad     = (req_dat.imm[31:16] != '0);
            end
            default: bad = 1'b1;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign enc_vld = in_valid && !bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= accept && bad;
    end

    fifo #(.W(32), .DEPTH(2)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (enc_vld),
        .push_rdy (in_ready),
        .push_dat (enc_dat),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (instruction)
    );
endmodule

// File: tb/tb_encoder_m.sv
// Directed bench for encoder_m: hand-computed LEGv8 words, reject handling, FIFO order, reset.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_encoder_m;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready;
    logic [3:0]  op;
    logic [4:0]  rd, rn, rm;
    logic [31:0] imm;
    logic [1:0]  hw;
    logic        in_ready, out_valid, err;
    logic [31:0] instruction;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd, rn, rm;
        logic [31:0] imm;
        logic [1:0]  hw;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7] = '{
        '{4'd3,  5'd7, 5'd0,  5'd0, 32'hFFFF_FFFC, 2'd0, 32'hB5FF_FF87}, // CBNZ -4
        '{4'd5,  5'd2, 5'd31, 5'd0, 32'hFFFF_FF00, 2'd0, 32'hF810_03E2}, // STUR -256
        '{4'd11, 5'd3, 5'd4,  5'd0, 32'hFFFF_FFFF, 2'd0, 32'hD13F_FC83}, // SUBI -1
        '{4'd14, 5'd9, 5'd0,  5'd0, 32'h0000_ABCD, 2'd2, 32'hF2D5_79A9}, // MOVK
        '{4'd9,  5'd0, 5'd1,  5'd2, 32'hFFFF_FFFF, 2'd0, 32'hAA02_0020}, // ORR, imm ignored
        '{4'd0,  5'd0, 5'd0,  5'd0, 32'h01FF_FFFF, 2'd0, 32'h15FF_FFFF}, // B max offset
        '{4'd10, 5'd0, 5'd0,  5'd0, 32'h0000_07FF, 2'd0, 32'h911F_FC00}  // ADDI 2047
    };

    always #5 clk = ~clk;

    encoder_m dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .rd          (rd),
        .rn          (rn),
        .rm          (rm),
        .imm         (imm),
        .hw          (hw),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instruction (instruction),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] o, input logic [4:0] d, input logic [4:0] n,
                           input logic [4:0] m, input logic [31:0] i, input logic [1:0] h);
        op = o; rd = d; rn = n; rm = m; imm = i; hw = h;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [3:0] o, input logic [4:0] d, input logic [4:0] n,
                        input logic [4:0] m, input logic [31:0] i, input logic [1:0] h);
        set_req(o, d, n, m, i, h);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; rd = '0; rn = '0; rm = '0; imm = '0; hw = '0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_instruction", instruction, 0);
        chk("rst_err", err, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Basic ADD with one-cycle latency
        out_ready = 1'b1;
        send(4'd6, 5'd1, 5'd2, 5'd3, 32'd0, 2'd0);
        chk("add_valid", out_valid, 1);
        chk("add_word", instruction, 32'h8B03_0041);
        chk("add_err", err, 0);
        tick();
        chk("add_drained", out_valid, 0);

        // B -1 then LDUR back to back
        send(4'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 2'd0);
        chk("b_neg1", instruction, 32'h17FF_FFFF);
        send(4'd4, 5'd5, 5'd6, 5'd0, 32'd8, 2'd0);
        chk("ldur", instruction, 32'hF840_80C5);
        chk("ldur_valid", out_valid, 1);

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm, vecs[i].hw);
            chk($sformatf("vec%0d_word", i), instruction, vecs[i].exp);
            chk($sformatf("vec%0d_err", i), err, 0);
        end
        tick();
        chk("vec_drained", out_valid, 0);

        // Rejects with empty FIFO
        send(4'd10, 5'd1, 5'd1, 5'd0, 32'd4096, 2'd0);
        chk("addi4096_err", err, 1);
        chk("addi4096_valid", out_valid, 0);
        tick();
        chk("addi4096_err_clear", err, 0);
        send(4'd15, 5'd1, 5'd1, 5'd1, 32'd0, 2'd0);
        chk("illegal_err", err, 1);
        chk("illegal_valid", out_valid, 0);
        tick();
        chk("illegal_err_clear", err, 0);

        // Back-to-back rejects at each range edge
        set_req(4'd4, 5'd0, 5'd0, 5'd0, 32'd256, 2'd0);
        tick();
        chk("ldur256_err", err, 1);
        set_req(4'd14, 5'd0, 5'd0, 5'd0, 32'h0001_0000, 2'd0);
        tick();
        chk("movk65536_err", err, 1);
        set_req(4'd0, 5'd0, 5'd0, 5'd0, 32'h0200_0000, 2'd0);
        tick();
        chk("b_2p25_err", err, 1);
        set_req(4'd3, 5'd0, 5'd0, 5'd0, 32'hFFFB_FFFF, 2'd0);
        tick();
        chk("cbnz_under_err", err, 1);
        in_valid = 1'b0;
        tick();
        chk("b2b_err_clear", err, 0);
        chk("b2b_valid", out_valid, 0);

        // Reject while one word is queued leaves count and head untouched
        out_ready = 1'b0;
        send(4'd6, 5'd1, 5'd2, 5'd3, 32'd0, 2'd0);
        send(4'd11, 5'd0, 5'd0, 5'd0, 32'hFFFF_F7FF, 2'd0);
        chk("rej_q_err", err, 1);
        chk("rej_q_head", instruction, 32'h8B03_0041);
        chk("rej_q_in_ready", in_ready, 1);
        send(4'd6, 5'd4, 5'd0, 5'd0, 32'd0, 2'd0);
        chk("rej_q_full", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("rej_q_second", instruction, 32'h8B00_0004);
        tick();
        chk("rej_q_drained", out_valid, 0);

        // Three requests against a stalled consumer
        out_ready = 1'b0;
        set_req(4'd6, 5'd1, 5'd0, 5'd0, 32'd0, 2'd0);
        tick();
        set_req(4'd6, 5'd2, 5'd0, 5'd0, 32'd0, 2'd0);
        tick();
        set_req(4'd6, 5'd3, 5'd0, 5'd0, 32'd0, 2'd0);
        chk("stall_in_ready", in_ready, 0);
        tick();
        chk("stall_in_ready_hold", in_ready, 0);
        chk("stall_head", instruction, 32'h8B00_0001);
        out_ready = 1'b1;
        tick();
        chk("drain_1", instruction, 32'h8B00_0002);
        chk("drain_1_in_ready", in_ready, 1);
        tick();
        chk("drain_2", instruction, 32'h8B00_0003);
        chk("drain_2_valid", out_valid, 1);
        in_valid = 1'b0;
        tick();
        chk("drain_done", out_valid, 0);

        // Steady push/pop at count=1
        out_ready = 1'b0;
        send(4'd6, 5'd10, 5'd0, 5'd0, 32'd0, 2'd0);
        chk("pp_first", instruction, 32'h8B00_000A);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            set_req(4'd6, 5'(10 + k), 5'd0, 5'd0, 32'd0, 2'd0);
            tick();
            chk($sformatf("pp%0d_valid", k), out_valid, 1);
            chk($sformatf("pp%0d_word", k), instruction, 32'h8B00_0000 + 32'(10 + k));
        end
        in_valid = 1'b0;
        tick();
        chk("pp_drained", out_valid, 0);

        // Asynchronous reset with a full FIFO
        out_ready = 1'b0;
        send(4'd6, 5'd20, 5'd0, 5'd0, 32'd0, 2'd0);
        send(4'd6, 5'd21, 5'd0, 5'd0, 32'd0, 2'd0);
        chk("full_in_ready", in_ready, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_word", instruction, 0);
        chk("arst_in_ready", in_ready, 0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_valid", out_valid, 0);
        tick();
        chk("rel_no_stale", out_valid, 0);
        out_ready = 1'b1;
        send(4'd7, 5'd1, 5'd2, 5'd3, 32'd0, 2'd0);
        chk("rel_sub_word", instruction, 32'hCB03_0041);
        tick();
        chk("rel_sub_drained", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
